// File: rtl/pipe_ctl_pkg.sv
// rtl/pipe_ctl_pkg.sv - shared types and constants for the pipeline valid/flush controller
// Contents: pipe_state_t (RUN/DRAIN/HALTED), STATE_W, PERF_W, PERF_SAT, sat_add().
package pipe_ctl_pkg;

    localparam int STATE_W = 2;
    localparam int PERF_W  = 16;
    localparam logic [PERF_W-1:0] PERF_SAT = 16'hFFFF;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pipe_state_t;

    // Saturating add for the performance counters; never wraps past PERF_SAT.
    function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] a,
                                                  input logic [PERF_W-1:0] b);
        logic [PERF_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PERF_W] ? PERF_SAT : s[PERF_W-1:0];
    endfunction

endpackage

// File: rtl/valid_stage.sv
// rtl/valid_stage.sv - single pipeline valid flop with clear, hold and load
// Ports: i_clk, i_reset (sync, active-high), i_clr (force 0), i_hold (keep value),
//        i_d (value loaded otherwise), o_q (registered valid bit).
module valid_stage (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_hold,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset)     r_q <= 1'b0;
        else if (i_clr)  r_q <= 1'b0;
        else if (!i_hold) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_flush_ctl.sv
// rtl/pipe_flush_ctl.sv - per-stage valid tracking, branch squash, stall bubbles and halt/drain FSM
// Ports: clk, reset (sync, active-high), issue, stall, branch, halt (inputs);
//        stage_valid[DEPTH], squash[DEPTH], wb_ok, fetch_hold, squash_cnt[CNT_W], state[2] (outputs).
// Optional macro PIPE_PERF_CNT_EN adds squash_total[16] and stall_cycles[16] saturating counters.
module pipe_flush_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int BR_STAGE    = 2,
    parameter int STALL_STAGE = 0,
    parameter int CNT_W       = $clog2(DEPTH+1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue,
    input  logic               stall,
    input  logic               branch,
    input  logic               halt,
    output logic [DEPTH-1:0]   stage_valid,
    output logic [DEPTH-1:0]   squash,
    output logic               wb_ok,
    output logic               fetch_hold,
    output logic [CNT_W-1:0]   squash_cnt,
`ifdef PIPE_PERF_CNT_EN
    output logic [PERF_W-1:0]  squash_total,
    output logic [PERF_W-1:0]  stall_cycles,
`endif
    output logic [STATE_W-1:0] state
);

    pipe_state_t      r_state, w_state_nxt;
    logic [DEPTH-1:0] w_v, w_clr, w_hold, w_d;
    logic [CNT_W-1:0] r_squash_cnt, w_pop;
    logic             w_br_take, w_stall_eff;

    // A branch only counts when the resolving stage holds a real instruction.
    assign w_br_take   = ~reset & branch & w_v[BR_STAGE];
    assign w_stall_eff = ~reset & stall & ~w_br_take;

    // Per-stage control: branch clears the young side and lets the branch itself
    // move on; stall freezes the young side and injects a bubble behind it.
    always_comb begin
        w_clr  = '0;
        w_hold = '0;
        w_d    = '0;
        w_d[0] = issue & (r_state == ST_RUN);
        for (int i = 1; i < DEPTH; i++) w_d[i] = w_v[i-1];
        if (w_br_take) begin
            for (int i = 0; i <= BR_STAGE; i++) w_clr[i] = 1'b1;
            w_d[BR_STAGE+1] = 1'b1;
        end else if (w_stall_eff) begin
            for (int i = 0; i <= STALL_STAGE; i++) w_hold[i] = 1'b1;
            w_clr[STALL_STAGE+1] = 1'b1;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        valid_stage u_stage (
            .i_clk   (clk),
            .i_reset (reset),
            .i_clr   (w_clr[g]),
            .i_hold  (w_hold[g]),
            .i_d     (w_d[g]),
            .o_q     (w_v[g])
        );
    end

    // Wrong-path instructions are the valid ones younger than the branch.
    always_comb begin
        squash = '0;
        w_pop  = '0;
        for (int i = 0; i < BR_STAGE; i++) begin
            w_pop = w_pop + CNT_W'(w_v[i]);
            if (w_br_take) squash[i] = w_v[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_squash_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_br_take) r_squash_cnt <= w_pop;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            // A taken branch in the same cycle means the halt was on the wrong path.
            ST_RUN:    if (halt & (w_v[0] | issue) & ~w_br_take) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_v == '0) w_state_nxt = ST_HALTED;
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] r_squash_total, r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_squash_total <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_br_take)   r_squash_total <= sat_add(r_squash_total, PERF_W'(w_pop));
            if (w_stall_eff) r_stall_cycles <= sat_add(r_stall_cycles, PERF_W'(1));
        end
    end

    assign squash_total = r_squash_total;
    assign stall_cycles = r_stall_cycles;
`endif

    assign stage_valid = w_v;
    assign wb_ok       = w_v[DEPTH-1];
    assign squash_cnt  = r_squash_cnt;
    assign state       = r_state;
    assign fetch_hold  = ~reset & (w_stall_eff | (r_state != ST_RUN));

endmodule

// File: doc/pipe_flush_ctl.md
Name: pipe_flush_ctl

Overview:
- Parametrised pipeline valid/flush controller; next generation of the fixed 3-cycle branch-hold shifter in the single-cycle-pipelined CPU control path.
- Tracks a per-stage valid bit for DEPTH stages after fetch, squashes wrong-path instructions on a taken branch, and freezes or bubbles stages on a stall.
- Runs a halt/drain state machine.
- Writeback and dmem write enables are gated by this block's outputs instead of a fixed-length hold.

Parameters:
- DEPTH, 4, number of tracked stages after fetch; index 0 = decode, DEPTH-1 = writeback/next.
- BR_STAGE, 2, stage index where branches resolve; legal range 1..DEPTH-2.
- STALL_STAGE, 0, youngest-to-oldest freeze boundary; stages 0..STALL_STAGE hold on stall; legal range 0..BR_STAGE-1.
- CNT_W, $clog2(DEPTH+1), width of squash count.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- issue  in  1  fetch presented an instruction this cycle.
- stall  in  1  hazard stall request, such as load-use.
- branch  in  1  taken branch/jump resolved in stage BR_STAGE.
- halt  in  1  halt instruction decoded.
- stage_valid  out  DEPTH  registered valid bit per stage.
- squash  out  DEPTH  combinational mask of valid stages killed this cycle.
- wb_ok  out  1  equals stage_valid[DEPTH-1]; gates rfWriteEn/dmemWrite.
- fetch_hold  out  1  combinational; PC must not advance this cycle.
- squash_cnt  out  CNT_W  count of valid instructions killed by the most recent taken branch, registered.
- state  out  2  RUN=0, DRAIN=1, HALTED=2.

Behaviour:
- Reset: stage_valid=0, squash_cnt=0, state=RUN. squash=0 and fetch_hold=0 during reset.
- br_take = branch & stage_valid[BR_STAGE]. A branch on an invalid stage is ignored.
- Priority: reset > br_take > stall > normal advance.
- Normal advance:
  - v[0] <= issue & (state==RUN).
  - v[i] <= v[i-1] for i ≥ 1.
  - The oldest stage retires.
- br_take:
  - squash[i] = v[i] for i < BR_STAGE.
  - v[0..BR_STAGE] <= 0, including v[0]; issue is ignored this cycle.
  - v[BR_STAGE+1] <= 1. The branch itself completes.
  - Older stages advance normally.
  - squash_cnt <= popcount(v[0..BR_STAGE-1]).
  - A stall in the same cycle is ignored.
- stall without br_take:
  - Stages 0..STALL_STAGE hold.
  - v[STALL_STAGE+1] <= 0 (bubble).
  - Older stages advance.
  - fetch_hold=1.
- Latency: a branch resolved at cycle n gives wb_ok=0 for the squashed slots arriving at DEPTH-1 over the next BR_STAGE cycles. No fixed hold length.
- FSM:
  - RUN→DRAIN when halt & (stage_valid[0] | issue) and no br_take; the halt must be on the valid path.
  - A branch taken in the same cycle as halt cancels the halt; stay in RUN.
  - DRAIN: issue ignored, fetch_hold=1. DRAIN→HALTED when stage_valid==0 at the clock edge.
  - br_take in DRAIN still squashes normally.
  - HALTED: fetch_hold=1, all valid bits stay 0, and the state is left only by reset.
- Reset mid-drain or mid-squash returns to RUN with all bits clear the next cycle.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, adds two ports:
  - squash_total out 16: saturating sum of squash_cnt increments.
  - stall_cycles out 16: saturating count of cycles with stall & ~br_take.
- Both counters clear on reset and saturate at 16'hFFFF with no wrap.
- When undefined, the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Package pipe_ctl_pkg: state encoding RUN/DRAIN/HALTED, state width 2, counter width 16, saturation constant.
- One sub-module, valid_stage: a single valid flop with hold, clear and load inputs, instantiated DEPTH times by a generate loop.
- FSM and popcount stay in the top module.

Test Plan:
All scenarios use DEPTH=4, BR_STAGE=2, STALL_STAGE=0.
- Reset, then issue=1 for 6 cycles: stage_valid goes 0001→0011→0111→1111; wb_ok=1 from cycle 4.
- Steady 1111, pulse branch=1: squash=0011, squash_cnt=2, next stage_valid=1000, then 0000 if issue=0; wb_ok low for the two squashed slots.
- Steady 1111, stall=1 for 1 cycle: fetch_hold=1; next stage_valid=1101 (v0 held, v1 bubble).
- branch and stall in the same cycle with v=0111: branch wins; next v=1000, fetch_hold=0.
- halt with v=0001, then no branch: DRAIN with v shifting 0010→0100→1000→0000, then HALTED; issue is ignored throughout; the next reset returns to RUN.
- PIPE_PERF_CNT_EN defined: 70000 stall cycles give stall_cycles=16'hFFFF with no wrap; reset gives 0.
